// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for the N-to-1 stream multiplexer: per-channel inputs,
// selection controls and the single registered output stream.
interface stream_mux_rr_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) ();
    localparam int SW = $clog2(CHANNELS);

    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic                      mode;
    logic [SW-1:0]             sel;
    logic [WIDTH-1:0]          out_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [SW-1:0]             out_chan;

    // master: the environment driving channels and consuming the output
    modport master (
        output in_data, in_valid, mode, sel, out_ready,
        input  in_ready, out_data, out_valid, out_chan
    );

    // slave: the multiplexer itself
    modport slave (
        input  in_data, in_valid, mode, sel, out_ready,
        output in_ready, out_data, out_valid, out_chan
    );
endinterface

// File: rtl/stream_mux_rr.sv
// N-to-1 stream multiplexer with round-robin or fixed channel selection and a
// single registered output stage that sustains one word per cycle.
module stream_mux_rr #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic            clk,
    input  logic            rst,
    stream_mux_rr_if.slave  bus
);
    localparam int SW = $clog2(CHANNELS);
    localparam logic [SW:0] CH_W   = (SW+1)'(CHANNELS);
    localparam logic [SW-1:0] LAST = SW'(CHANNELS - 1);

    logic [SW-1:0] rr_ptr;
    logic [SW-1:0] grant_idx;
    logic          grant_vld;
    logic          load_en;
    logic          accept;

    assign load_en = !bus.out_valid || bus.out_ready;
    assign accept  = grant_vld && load_en;

    always_comb begin
        logic [SW:0] cand;
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (bus.mode) begin
            // an out-of-range sel can only occur when CHANNELS is not a power of two
            if ({1'b0, bus.sel} < CH_W && bus.in_valid[bus.sel]) begin
                grant_vld = 1'b1;
                grant_idx = bus.sel;
            end
        end else begin
            for (int k = 0; k < CHANNELS; k++) begin
                cand = {1'b0, rr_ptr} + (SW+1)'(k);
                if (cand >= CH_W) cand = cand - CH_W;
                if (!grant_vld && bus.in_valid[cand[SW-1:0]]) begin
                    grant_vld = 1'b1;
                    grant_idx = cand[SW-1:0];
                end
            end
        end
    end

    always_comb begin
        bus.in_ready = '0;
        if (accept && !rst) bus.in_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_chan  <= '0;
            rr_ptr        <= '0;
        end else begin
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
                bus.out_chan  <= grant_idx;
                if (!bus.mode)
                    rr_ptr <= (grant_idx == LAST) ? '0 : grant_idx + SW'(1);
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed self-checking bench for stream_mux_rr (WIDTH=16, CHANNELS=4).
`timescale 1ns/1ps
module tb_stream_mux_rr;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    stream_mux_rr_if #(.WIDTH(16), .CHANNELS(4)) bus ();

    stream_mux_rr #(.WIDTH(16), .CHANNELS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] chd [4];

    // sample 1 ns after the active edge; inputs change only here
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [15:0] d, input logic [1:0] c);
        total++;
        if (bus.out_valid !== v || (v && (bus.out_data !== d || bus.out_chan !== c))) begin
            bad++;
            $display("FAIL %s got v=%0b d=%h c=%0d want v=%0b d=%h c=%0d",
                     nm, bus.out_valid, bus.out_data, bus.out_chan, v, d, c);
        end
    endtask

    task automatic test_reset();
        bus.mode = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 4'b0010;
        step();
        chk_out("reset_preload", 1'b1, 16'h1234, 2'd1);
        bus.in_valid = 4'b0000;
        #3 rst = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== 16'h0000 || bus.out_chan !== 2'd0) begin
            bad++;
            $display("FAIL async_reset got v=%0b d=%h c=%0d want v=0 d=0000 c=0",
                     bus.out_valid, bus.out_data, bus.out_chan);
        end
        bus.in_valid = 4'b1111;
        #1;
        total++;
        if (bus.in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL ready_in_reset got %b want 0000", bus.in_ready);
        end
        bus.in_valid = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_ch [5];
        exp_ch = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        bus.mode = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 4'b1111;
        #1;
        total++;
        if (bus.in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL rr_first_ready got %b want 0001", bus.in_ready);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("rr_seq[%0d]", i), 1'b1, chd[exp_ch[i]], exp_ch[i]);
        end
        bus.in_valid = 4'b0000;
        step();
        chk_out("rr_drain", 1'b0, 16'h0, 2'd0);
    endtask

    task automatic test_fixed();
        bus.mode = 1'b1; bus.sel = 2'd2; bus.out_ready = 1'b1; bus.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.in_ready !== 4'b0100) begin
                bad++;
                $display("FAIL fixed_ready[%0d] got %b want 0100", i, bus.in_ready);
            end
            step();
            chk_out($sformatf("fixed_word[%0d]", i), 1'b1, 16'hAAAA, 2'd2);
        end
        bus.in_valid = 4'b0000;
        step();
        chk_out("fixed_drain", 1'b0, 16'h0, 2'd0);
    endtask

    task automatic test_fixed_invalid();
        bus.mode = 1'b1; bus.sel = 2'd1; bus.out_ready = 1'b1; bus.in_valid = 4'b1101;
        #1;
        total++;
        if (bus.in_ready !== 4'b0000) begin
            bad++;
            $display("FAIL sel_invalid_ready got %b want 0000", bus.in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("sel_invalid_idle[%0d]", i), 1'b0, 16'h0, 2'd0);
        end
        bus.in_valid = 4'b0000;
    endtask

    // rr_ptr is 1 here, so only ch1 valid is granted; afterwards rr_ptr=2
    task automatic test_backpressure();
        bus.mode = 1'b0; bus.out_ready = 1'b0; bus.in_valid = 4'b0010;
        step();
        chk_out("bp_load", 1'b1, 16'h1234, 2'd1);
        bus.in_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (bus.in_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready[%0d] got %b want 0000", i, bus.in_ready);
            end
            step();
            chk_out($sformatf("bp_hold[%0d]", i), 1'b1, 16'h1234, 2'd1);
        end
        bus.in_valid = 4'b1000; bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.in_ready !== 4'b1000) begin
            bad++;
            $display("FAIL bp_release_ready got %b want 1000", bus.in_ready);
        end
        step();
        chk_out("bp_next_word", 1'b1, 16'h5555, 2'd3);
        bus.in_valid = 4'b0000;
        step();
        chk_out("bp_drain", 1'b0, 16'h0, 2'd0);
    endtask

    // rr_ptr is 0 here
    task automatic test_wrap();
        bus.mode = 1'b0; bus.out_ready = 1'b1; bus.in_valid = 4'b1000;
        step();
        chk_out("wrap_ch3", 1'b1, 16'h5555, 2'd3);
        bus.in_valid = 4'b0001;
        #1;
        total++;
        if (bus.in_ready !== 4'b0001) begin
            bad++;
            $display("FAIL wrap_ready got %b want 0001", bus.in_ready);
        end
        step();
        chk_out("wrap_ch0", 1'b1, 16'h0000, 2'd0);
        bus.in_valid = 4'b1111;
        #1;
        total++;
        if (bus.in_ready !== 4'b0010) begin
            bad++;
            $display("FAIL wrap_ptr_ready got %b want 0010", bus.in_ready);
        end
        step();
        chk_out("wrap_ptr_word", 1'b1, 16'h1234, 2'd1);
        bus.in_valid = 4'b0000;
        step();
        chk_out("wrap_drain", 1'b0, 16'h0, 2'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        chd   = '{16'h0000, 16'h1234, 16'hAAAA, 16'h5555};
        bus.in_data   = {16'h5555, 16'hAAAA, 16'h1234, 16'h0000};
        bus.in_valid  = 4'b0000;
        bus.mode      = 1'b0;
        bus.sel       = 2'd0;
        bus.out_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #6 rst = 1'b0;
        step();
        chk_out("post_reset_idle", 1'b0, 16'h0, 2'd0);
        test_reset();
        test_round_robin();
        test_fixed();
        test_fixed_invalid();
        test_backpressure();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stream_mux_rr.md
STREAM_MUX_RR -- requirements
Module: stream_mux_rr

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data width in bits of each channel and of the output.
REQ-002 SHALL have parameter CHANNELS, default 4, number of input channels (legal range 2..16).
REQ-003 SHALL define SW = clog2(CHANNELS) as the width of all channel-index signals.
REQ-004 SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; asynchronous and active-high.
REQ-006 SHALL have port in_data  input  CHANNELS*WIDTH  channel i data at bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port in_valid  input  CHANNELS  per-channel valid.
REQ-008 SHALL have port in_ready  output  CHANNELS  per-channel ready; combinational.
REQ-009 SHALL have port mode  input  1  selection mode: 0 = round-robin, 1 = fixed select.
REQ-010 SHALL have port sel  input  SW  selected channel index, used only when mode=1.
REQ-011 SHALL have port out_data  output  WIDTH  registered output data.
REQ-012 SHALL have port out_valid  output  1  registered output valid.
REQ-013 SHALL have port out_ready  input  1  downstream ready.
REQ-014 SHALL have port out_chan  output  SW  registered source-channel index of out_data.

Function
REQ-015 SHALL accept a channel transfer on a cycle where in_valid[i] && in_ready[i], and an output transfer on a cycle where out_valid && out_ready.
REQ-016 SHALL compute load_en = !out_valid || out_ready, combinationally.
REQ-017 SHALL, in mode=0, grant the first channel with in_valid set, searching upward from rr_ptr and wrapping from CHANNELS-1 to 0.
REQ-018 SHALL, in mode=1, grant channel sel only when in_valid[sel]=1; it grants no other channel.
REQ-019 SHALL, in mode=1 with sel >= CHANNELS, grant no channel and leave in_ready all 0.
REQ-020 SHALL drive in_ready[i]=1 only for the granted channel and only when load_en=1; all other bits are 0 (one-hot or zero).
REQ-021 SHALL, on an accepted channel transfer, on the next edge load out_data with that channel's data, load out_chan with its index, and set out_valid=1 (latency 1 cycle).
REQ-022 SHALL, on an output transfer with no channel transfer on the same cycle, clear out_valid on the next edge; out_data and out_chan hold their values.
REQ-023 SHALL, on a cycle with both an output transfer and a channel transfer, replace the output with the new word and keep out_valid=1 (sustains 1 word/cycle).
REQ-024 SHALL, while out_valid=1 and out_ready=0, hold out_data, out_chan and out_valid stable and drive in_ready all 0.
REQ-025 SHALL, on every accepted transfer in mode=0, set rr_ptr to (granted index + 1) mod CHANNELS.
REQ-026 SHALL leave rr_ptr unchanged in mode=1 and on cycles with no accepted transfer.
REQ-027 SHALL apply a change of mode or sel to grant decisions on that same cycle; the word already held in the output register is unaffected.
REQ-028 SHALL never drop or duplicate an accepted word, and never present a word that was not accepted.

Reset
REQ-029 SHALL, on rst asserted and independent of clk, force out_valid=0, out_data=0, out_chan=0 and rr_ptr=0.
REQ-030 SHALL hold in_ready all 0 while rst=1.
REQ-031 SHALL discard a word held in the output register when reset occurs mid-operation; after rst deasserts, operation resumes from the first rising edge of clk.

Verification (WIDTH=16, CHANNELS=4)
REQ-032 SHALL cover: reset pulse between clock edges -> out_valid=0, out_data=16'h0000 and out_chan=0 immediately, before the next edge.
REQ-033 SHALL cover: mode=0, all valid, data ch0..ch3 = 16'h0000, 16'h1234, 16'hAAAA, 16'h5555, out_ready=1 -> out_chan sequence 0,1,2,3,0 on consecutive cycles, each with its matching data.
REQ-034 SHALL cover: mode=1, sel=2, all valid -> every output word is 16'hAAAA with out_chan=2, and in_ready=4'b0100.
REQ-035 SHALL cover: mode=1, sel=1, in_valid=4'b1101 -> in_ready=4'b0000 and out_valid stays 0.
REQ-036 SHALL cover: out_valid=1 and out_ready=0 for 3 cycles -> out_data holds, in_ready=0; then out_ready=1 with ch3 valid (16'h5555) -> next word is 16'h5555 with no idle cycle.
REQ-037 SHALL cover: mode=0, only ch3 valid, then only ch0 valid -> ch3 is granted, then ch0 is granted via wrap-around, and rr_ptr=1 afterwards.
